display_scheduler: RTL
======================

# display_scheduler

Sequencing controller for the board's seven-segment display path. It shares the single 32-bit display word and its zero flag among four requesters (for example PC, ALU result, memory data and register readout). Requesters are served round-robin, and each granted value is held for a programmable dwell time. A manual mode lets the board switches pin one source. Registered outputs drive the existing segment decoder directly.

## Interface
Parameters:
- DWELL, 50_000_000, display hold time in clock cycles per grant; legal range ≥ 1
- CW, $clog2(DWELL+1), dwell counter width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- req  in  4  per-source request, level, held by source until acked
- src_data  in  128  source i word at bits [32*i+31 : 32*i]
- src_zero  in  4  source i zero flag
- mode  in  1  0 = arbitrated, 1 = manual
- sel  in  2  manual-mode source index
- freeze  in  1  halts dwell countdown and blocks new grants
- ack  out  4  one-hot grant strobe, 1 cycle
- entrada  out  32  word to segment decoder
- zero  out  1  zero flag to segment decoder
- cur_src  out  2  index of displayed source
- busy  out  1  high while a dwell is in progress

## Operation
- States: IDLE, SHOW, MANUAL.
- Reset (reset=0 at a rising edge) sets all of the following:
  - state = IDLE, rr pointer = 0, counter = 0
  - ack = 0, entrada = 0, zero = 0, cur_src = 0, busy = 0
- IDLE (mode=0):
  - If freeze = 0 and any req is set, select the first set req searching ptr, ptr+1, … modulo 4.
  - Pulse ack[i] for one cycle.
  - Latch entrada = src_data[i], zero = src_zero[i], cur_src = i.
  - Update ptr = (i+1) mod 4, counter = DWELL−1, busy = 1, then go to SHOW.
  - With no req, or with freeze = 1, stay in IDLE. Outputs hold their last value; no blanking.
- SHOW (mode=0):
  - freeze = 1: counter holds.
  - freeze = 0 and counter ≠ 0: counter decrements.
  - freeze = 0 and counter = 0: go to IDLE, busy = 0.
  - Requests arriving in SHOW wait; they are never acked in SHOW.
- MANUAL (entered from any state on the edge where mode = 1):
  - Any dwell in progress is aborted; busy = 0, ack = 0.
  - Each cycle, latch entrada = src_data[sel], zero = src_zero[sel], cur_src = sel.
  - freeze = 1 holds the outputs.
  - The rr pointer is unchanged.
  - mode = 0 returns the block to IDLE on the next edge.
- ack is asserted only when the corresponding req is 1 in the same cycle. Sources must keep data stable while req = 1. Data is captured on the ack edge only.
- At most one ack bit is high in any cycle.
- The decoder consumes entrada/zero combinationally; no decoding is done in this block.

## Timing
- Grant latency: req sampled high in IDLE at edge k produces ack, entrada, cur_src and busy valid after edge k.
- ack is high for exactly one cycle, k→k+1.
- busy is high for exactly DWELL cycles after a grant if freeze stays 0.
- Busy is followed by 1 IDLE cycle. A continuously requesting set therefore sees grants every DWELL+1 cycles.
- DWELL = 1: SHOW lasts one cycle, giving a grant period of 2.
- Each cycle with freeze = 1 in SHOW extends the dwell by one cycle.
- Manual mode latency: a change on sel or src_data appears on the outputs one edge later.
- Mode switch 0→1 mid-SHOW: the next edge enters MANUAL and drops busy; the dwell is not resumed.
- Reset mid-SHOW clears everything on that edge. Any req still high is re-arbitrated from ptr = 0 after reset is released.

## Test plan
- DWELL=4, reset released, req=4'b0100, src_data[2]=32'h0000_00AB, src_zero[2]=0:
  - ack=4'b0100 for 1 cycle; entrada=32'hAB, cur_src=2, busy high 4 cycles.
  - IDLE 1 cycle, then re-grant of src 2.
- DWELL=4, req=4'b1111 held, all ack observed:
  - grant order 0,1,2,3,0; grants 5 cycles apart; never two ack bits high together.
- DWELL=4, grant src 1, then freeze=1 for 3 cycles during SHOW:
  - busy high 7 cycles total; no ack while frozen, including in IDLE.
- DWELL=4, src 0 granted, mode→1 after 2 SHOW cycles with sel=3, src_data[3]=32'hDEAD_BEEF, src_zero[3]=1:
  - next edge busy=0, entrada=32'hDEADBEEF, zero=1, cur_src=3, no ack.
  - mode→0 then grants src 1 first (ptr preserved).
- reset=0 for one edge during SHOW:
  - all outputs 0 on that edge; with req=4'b1000 held, first grant after release is src 3 one cycle later.
- DWELL=1, req=4'b0011 held:
  - acks alternate src 0, src 1 every 2 cycles; busy toggles 1,0.

Source files
------------

// File: rtl/display_scheduler_if.sv
// display_scheduler_if: bundles requester handshake, source data and display outputs
// Ports (signals):
//   req      [3:0]   per-source request level, held until acked
//   src_data [127:0] source i word at [32*i+31:32*i]
//   src_zero [3:0]   source i zero flag
//   ack      [3:0]   one-hot grant strobe
//   entrada  [31:0]  word to segment decoder
//   zero             zero flag to segment decoder
//   cur_src  [1:0]   index of displayed source
//   busy             dwell in progress
interface display_scheduler_if;
    logic [3:0]   req;
    logic [127:0] src_data;
    logic [3:0]   src_zero;
    logic [3:0]   ack;
    logic [31:0]  entrada;
    logic         zero;
    logic [1:0]   cur_src;
    logic         busy;
    modport master (output req, src_data, src_zero, input ack, entrada, zero, cur_src, busy);
    modport slave  (input req, src_data, src_zero, output ack, entrada, zero, cur_src, busy);
endinterface

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin sharing of the seven-segment display word among four sources
// Ports:
//   clock   rising-edge system clock
//   reset   synchronous active-low reset
//   bus     display_scheduler_if.slave (req/src_data/src_zero in, ack/entrada/zero/cur_src/busy out)
//   mode    0 = arbitrated, 1 = manual
//   sel     manual-mode source index
//   freeze  halts dwell countdown, blocks grants and holds manual outputs
module display_scheduler #(
    parameter int DWELL = 50_000_000,
    parameter int CW    = $clog2(DWELL + 1)
) (
    input  logic                clock,
    input  logic                reset,
    display_scheduler_if.slave  bus,
    input  logic                mode,
    input  logic [1:0]          sel,
    input  logic                freeze
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHOW   = 2'd1;
    localparam logic [1:0] MANUAL = 2'd2;

    logic [1:0]    state;
    logic [1:0]    ptr;
    logic [1:0]    pick;
    logic          hit;
    logic [CW-1:0] cnt;

    // Search ptr, ptr+1, ... modulo 4; iterating downward lets the nearest hit win.
    always_comb begin
        hit  = 1'b0;
        pick = ptr;
        for (int j = 3; j >= 0; j--) begin
            if (bus.req[ptr + 2'(j)]) begin
                hit  = 1'b1;
                pick = ptr + 2'(j);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= 2'd0;
            cnt         <= '0;
            bus.ack     <= 4'd0;
            bus.entrada <= 32'd0;
            bus.zero    <= 1'b0;
            bus.cur_src <= 2'd0;
            bus.busy    <= 1'b0;
        end else begin
            bus.ack <= 4'd0;
            if (mode) begin
                // Manual mode overrides everything and abandons any dwell; ptr is kept.
                state    <= MANUAL;
                bus.busy <= 1'b0;
                if (!freeze) begin
                    bus.entrada <= bus.src_data[{sel, 5'd0} +: 32];
                    bus.zero    <= bus.src_zero[sel];
                    bus.cur_src <= sel;
                end
            end else if (state == MANUAL) begin
                state <= IDLE;
            end else if (state == SHOW) begin
                if (!freeze) begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
            end else if (!freeze && hit) begin
                bus.ack     <= 4'b0001 << pick;
                bus.entrada <= bus.src_data[{pick, 5'd0} +: 32];
                bus.zero    <= bus.src_zero[pick];
                bus.cur_src <= pick;
                ptr         <= pick + 2'd1;
                cnt         <= CW'(DWELL - 1);
                bus.busy    <= 1'b1;
                state       <= SHOW;
            end
        end
    end
endmodule
